// File: rtl/signed_bin_to_bcd_pkg.sv
// Shared types and constants for the signed binary-to-BCD converter.
// Used by signed_bin_to_bcd and its bcd_add3_adjust digit cells.
package signed_bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int                   BCD_DIG_W   = 4;
  localparam logic [BCD_DIG_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_DIG_W-1:0] ADD3_OFFSET = 4'd3;

  function automatic int bcd_width(input int ndig);
    return ndig * BCD_DIG_W;
  endfunction

endpackage

// File: rtl/signed_bin_to_bcd_add3.sv
// bcd_add3_adjust: combinational double-dabble digit cell.
// A digit of 5 or more is pre-corrected by +3 so that the following left shift carries into the next decade.
module bcd_add3_adjust
  import signed_bin_to_bcd_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] i_digit,
  output logic [BCD_DIG_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADD3_THRESH) begin
      o_digit = i_digit + ADD3_OFFSET;
    end
  end

endmodule

// File: rtl/signed_bin_to_bcd.sv
// Sequential signed binary to sign + packed BCD converter, one double-dabble bit per clock.
// Optional leading-zero blank flags are built only when LEADING_ZERO_BLANK_EN is defined.
//
// state | meaning
// IDLE  | ready for a new value, outputs hold the last result
// SHIFT | one adjust+shift iteration per edge, WIDTH edges total
// DONE  | out_valid strobe for one cycle, then back to IDLE
module signed_bin_to_bcd
  import signed_bin_to_bcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        out_sign,
  output logic [bcd_width(NDIG)-1:0]  out_bcd,
  output logic                        out_valid,
  output logic [NDIG-1:0]             out_blank
);

  localparam int BW    = bcd_width(NDIG);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(WIDTH);

  state_t             r_state;
  logic               r_sign;
  logic [WIDTH-1:0]   r_mag;
  logic [BW-1:0]      r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_sign;
  logic [BW-1:0]      r_out_bcd;
  logic               r_out_valid;

  logic [WIDTH-1:0]    w_abs;
  logic [BW-1:0]       w_adj;
  logic [BW+WIDTH-1:0] w_cat;
  logic [BW-1:0]       w_bcd_next;
  logic [WIDTH-1:0]    w_mag_next;

  // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
  assign w_abs = in_data[WIDTH-1] ? (~in_data + ONE_W) : in_data;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_add3_adjust u_adj (
      .i_digit (r_bcd[g*BCD_DIG_W +: BCD_DIG_W]),
      .o_digit (w_adj[g*BCD_DIG_W +: BCD_DIG_W])
    );
  end

  assign w_cat      = {w_adj, r_mag} << 1;
  assign w_bcd_next = w_cat[BW+WIDTH-1 -: BW];
  assign w_mag_next = w_cat[WIDTH-1:0];

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] w_blank;
  logic [NDIG-1:0] r_out_blank;

  always_comb begin
    logic hi_zero;
    w_blank = '0;
    hi_zero = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      hi_zero    = hi_zero & (w_bcd_next[i*BCD_DIG_W +: BCD_DIG_W] == '0);
      w_blank[i] = hi_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_blank <= '0;
    end else if (r_state == SHIFT && r_cnt == CNT_ONE) begin
      r_out_blank <= w_blank;
    end
  end

  assign out_blank = r_out_blank;
`else
  assign out_blank = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_out_sign  <= 1'b0;
      r_out_bcd   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign  <= in_data[WIDTH-1];
            r_mag   <= w_abs;
            r_bcd   <= '0;
            r_cnt   <= CNT_INI;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_next;
          r_mag <= w_mag_next;
          r_cnt <= r_cnt - CNT_ONE;
          // Outputs change only here, so the display never sees partial sums.
          if (r_cnt == CNT_ONE) begin
            r_out_bcd   <= w_bcd_next;
            r_out_sign  <= r_sign;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_sign  = r_out_sign;
  assign out_bcd   = r_out_bcd;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_signed_bin_to_bcd.sv
// Self-checking bench for signed_bin_to_bcd: directed corner cases plus random values against a decimal model.
// Build with LEADING_ZERO_BLANK_EN defined or not, matching the RTL build.
module tb_signed_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_sign;
  logic [11:0] out_bcd;
  logic        out_valid;
  logic [2:0]  out_blank;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  signed_bin_to_bcd #(.WIDTH(8), .NDIG(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sign  (out_sign),
    .out_bcd   (out_bcd),
    .out_valid (out_valid),
    .out_blank (out_blank)
  );

  function automatic int mag_of(input logic [7:0] d);
    int v;
    v = int'($signed(d));
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [11:0] model_bcd(input logic [7:0] d);
    int m;
    m = mag_of(d);
    return 12'(((m / 100) % 10) * 256 + ((m / 10) % 10) * 16 + (m % 10));
  endfunction

  function automatic logic model_sign(input logic [7:0] d);
    return int'($signed(d)) < 0;
  endfunction

  function automatic logic [2:0] model_blank(input logic [7:0] d);
    logic [2:0] b;
    int m;
    m = mag_of(d);
    b = 3'b000;
`ifdef LEADING_ZERO_BLANK_EN
    b[2] = (m < 100);
    b[1] = (m < 10);
`endif
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_conv(input logic [7:0] d, input string tag);
    int lat;
    logic [11:0] prev_bcd;
    logic prev_sign;
    bit stable;
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = 8'($urandom);
    prev_bcd  = out_bcd;
    prev_sign = out_sign;
    stable    = 1'b1;
    lat       = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid !== 1'b1 &&
          (out_bcd !== prev_bcd || out_sign !== prev_sign || in_ready !== 1'b0))
        stable = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_hold_busy"}, 32'(stable), 32'd1);
    check({tag, "_sign"}, 32'(out_sign), 32'(model_sign(d)));
    check({tag, "_bcd"}, 32'(out_bcd), 32'(model_bcd(d)));
    check({tag, "_blank"}, 32'(out_blank), 32'(model_blank(d)));
    check({tag, "_ready_done"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_strobe_1cyc"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int pulses;
    int pulse_cyc[2];
    logic [11:0] pulse_val[2];
    bit saw_valid;

    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_sign", 32'(out_sign), 32'd0);
    check("rst_bcd", 32'(out_bcd), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_blank", 32'(out_blank), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    run_conv(8'h7F, "pos_max");
    run_conv(8'h80, "neg_min");
    run_conv(8'hFF, "neg_one");
    run_conv(8'h00, "zero");
    run_conv(8'h0A, "ten");
    run_conv(8'h9C, "neg_100");

    for (int k = 0; k < 20; k++) begin
      run_conv(8'($urandom_range(0, 255)), "rand");
    end

    // Back-to-back with in_valid held high; the second value changes during SHIFT.
    @(negedge clk);
    in_data  = 8'd42;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data   = 8'd99;
    pulses    = 0;
    pulse_cyc = '{0, 0};
    pulse_val = '{12'h0, 12'h0};
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (pulses < 2) begin
          pulse_cyc[pulses] = c;
          pulse_val[pulses] = out_bcd;
        end
        pulses++;
      end
      if (c == 9) check("b2b_idle_ready", 32'(in_ready), 32'd1);
      if (c == 10) begin
        check("b2b_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_first_cyc", 32'(pulse_cyc[0]), 32'd8);
    check("b2b_first_val", 32'(pulse_val[0]), 32'h042);
    check("b2b_second_cyc", 32'(pulse_cyc[1]), 32'd18);
    check("b2b_second_val", 32'(pulse_val[1]), 32'h099);

    // Asynchronous reset in the middle of a conversion of -56.
    @(negedge clk);
    in_data  = 8'hC8;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(out_bcd), 32'd0);
    check("abort_sign", 32'(out_sign), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    saw_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    check("abort_no_strobe", 32'(saw_valid), 32'd0);
    run_conv(8'd5, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
